// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and sizing helpers for the sequential divider
package div_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int DIV_WIDTH = 4;
   localparam int CNT_W     = $clog2(DIV_WIDTH + 1);

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/fs_nbits.sv
// rtl/fs_nbits.sv - N-bit ripple full-subtractor chain, diff = i0 - i1 - bin
module fs_nbits #(
   parameter int N = 5
) (
   input  logic [N-1:0] i0,
   input  logic [N-1:0] i1,
   input  logic         bin,
   output logic [N-1:0] diff,
   output logic         bout
);

   logic [N:0] b;

   assign b[0] = bin;

   for (genvar g = 0; g < N; g++) begin : g_stage
      assign diff[g]  = i0[g] ^ i1[g] ^ b[g];
      assign b[g + 1] = (~i0[g] & i1[g]) | (~(i0[g] ^ i1[g]) & b[g]);
   end

   assign bout = b[N];

endmodule

// File: rtl/div_4bits_seq.sv
// rtl/div_4bits_seq.sv - sequential unsigned restoring divider, one quotient bit per clock
module div_4bits_seq
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quot,
   output logic [WIDTH-1:0] rem,
   output logic             dbz
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   a_reg, a_sh, a_nxt, t_diff;
   logic [WIDTH-1:0] q_reg, q_nxt, dvs;
   logic             bout;
   logic             last_step;

   // Shift {A,Q} left one place; A's MSB is always zero because A < divisor.
   assign a_sh      = (a_reg << 1) | {{WIDTH{1'b0}}, q_reg[WIDTH-1]};
   assign last_step = (cnt == CW'(1));

   fs_nbits #(
      .N (WIDTH + 1)
   ) u_fs (
      .i0   (a_sh),
      .i1   ({1'b0, dvs}),
      .bin  (1'b0),
      .diff (t_diff),
      .bout (bout)
   );

   always_comb begin
      a_nxt = bout ? a_sh : t_diff;
      q_nxt = (q_reg << 1) | {{(WIDTH-1){1'b0}}, ~bout};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = (i1 != '0) ? S_RUN : S_DONE;
         end
         S_RUN: begin
            if (last_step) state_nxt = S_DONE;
         end
         S_DONE: begin
            if (start) state_nxt = (i1 != '0) ? S_RUN : S_DONE;
            else       state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state == S_RUN);
      done = (state == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         a_reg <= '0;
         q_reg <= '0;
         dvs   <= '0;
         quot  <= '0;
         rem   <= '0;
         dbz   <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  if (i1 != '0) begin
                     dvs   <= i1;
                     a_reg <= '0;
                     q_reg <= i0;
                     cnt   <= CW'(WIDTH);
                     dbz   <= 1'b0;
                  end else begin
                     quot <= '1;
                     rem  <= i0;
                     dbz  <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               a_reg <= a_nxt;
               q_reg <= q_nxt;
               cnt   <= cnt - CW'(1);
               // Results land on the edge into DONE so they never show partial values.
               if (last_step) begin
                  quot <= q_nxt;
                  rem  <= a_nxt[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_4bits_seq.sv
// tb/tb_div_4bits_seq.sv - scoreboard bench for div_4bits_seq against an arithmetic reference
module tb_div_4bits_seq;

   localparam int WIDTH = 4;

   typedef struct {
      logic [WIDTH-1:0] i0;
      logic [WIDTH-1:0] i1;
      logic [WIDTH-1:0] quot;
      logic [WIDTH-1:0] rem;
      logic             dbz;
      int               due;
   } item_t;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] i0;
   logic [WIDTH-1:0] i1;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] rem;
   logic             dbz;

   item_t sb[$];
   int    cyc    = 0;
   int    checks = 0;
   int    errors = 0;
   int    bcnt   = 0;

   div_4bits_seq #(
      .WIDTH (WIDTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .i0    (i0),
      .i1    (i1),
      .busy  (busy),
      .done  (done),
      .quot  (quot),
      .rem   (rem),
      .dbz   (dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic item_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input int acc);
      item_t it;
      it.i0 = a;
      it.i1 = b;
      if (b == 0) begin
         it.quot = '1;
         it.rem  = a;
         it.dbz  = 1'b1;
         it.due  = acc;
      end else begin
         it.quot = WIDTH'(int'(a) / int'(b));
         it.rem  = WIDTH'(int'(a) % int'(b));
         it.dbz  = 1'b0;
         it.due  = acc + WIDTH;
      end
      return it;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every comparison in the bench happens here.
   always @(negedge clk) begin
      item_t it;
      if (!rst_n) begin
         bcnt = 0;
         chk("reset_busy", int'(busy), 0);
         chk("reset_done", int'(done), 0);
         chk("reset_quot", int'(quot), 0);
         chk("reset_rem",  int'(rem),  0);
         chk("reset_dbz",  int'(dbz),  0);
      end else begin
         if (busy) bcnt++;
         if (sb.size() > 0 && cyc > sb[0].due) begin
            it = sb.pop_front();
            chk("done_timeout", 0, 1);
         end
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               it = sb.pop_front();
               chk("quot", int'(quot), int'(it.quot));
               chk("rem",  int'(rem),  int'(it.rem));
               chk("dbz",  int'(dbz),  int'(it.dbz));
               chk("latency", cyc, it.due);
               chk("busy_cycles", bcnt, it.dbz ? 0 : WIDTH);
               if (!it.dbz) begin
                  chk("invariant", int'(quot) * int'(it.i1) + int'(rem), int'(it.i0));
                  chk("rem_lt_div", (rem < it.i1) ? 1 : 0, 1);
               end
            end
            bcnt = 0;
         end
      end
   end

   // mode 0: plain op; 1: spurious start during RUN; 2: reset in the 3rd RUN cycle
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int mode);
      @(negedge clk);
      i0    = a;
      i1    = b;
      start = 1'b1;
      sb.push_back(model(a, b, cyc + 1));
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         if (j == 1) begin
            start = 1'b0;
            i0    = WIDTH'($urandom);
            i1    = WIDTH'($urandom);
         end
         if (mode == 1 && j == 2) begin
            start = 1'b1;
            i0    = 4'd2;
            i1    = 4'd1;
         end
         if (mode == 1 && j == 3) start = 1'b0;
         if (mode == 2 && j == 3) begin
            #1 rst_n = 1'b0;
            sb.delete();
            repeat (2) @(negedge clk);
            #1 rst_n = 1'b1;
            break;
         end
         if (done) break;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      i0    = '0;
      i1    = '0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;

      run_op(4'd8,  4'd1, 0);
      run_op(4'd15, 4'd4, 0);
      run_op(4'd7,  4'd9, 0);
      run_op(4'd11, 4'd0, 0);
      run_op(4'd14, 4'd5, 1);
      run_op(4'd12, 4'd3, 2);
      repeat (2) @(negedge clk);
      run_op(4'd12, 4'd3, 0);

      // Back-to-back: start held high; second operands applied in the DONE cycle.
      @(negedge clk);
      i0    = 4'd9;
      i1    = 4'd2;
      start = 1'b1;
      sb.push_back(model(4'd9, 4'd2, cyc + 1));
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         if (done) break;
      end
      i0 = 4'd6;
      i1 = 4'd3;
      sb.push_back(model(4'd6, 4'd3, cyc + 1));
      @(negedge clk);
      start = 1'b0;
      for (int j = 0; j < 40; j++) begin
         @(negedge clk);
         if (done) break;
      end

      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            run_op(WIDTH'(a), WIDTH'(b), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end

      for (int k = 0; k < 60; k++) begin
         run_op(WIDTH'($urandom), WIDTH'($urandom), 0);
         repeat ($urandom_range(0, 1)) @(negedge clk);
      end

      repeat (10) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
